cpu_run_monitor: RTL and testbench
==================================

// Module: cpu_run_monitor
//
// PURPOSE
//   Parametrised reset sequencer and status monitor for the single-cycle CPU.
//   - Holds the core in reset for RST_HOLD cycles after system reset.
//   - Releases the core, then counts run cycles.
//   - Counts rising edges on N_FLAGS CPU status flags (e.g. equal, zero).
//   - Stops the core at a programmable cycle limit.
//   Sits between the board/bench clock-reset source and the CPU top. It
//   replaces open-coded reset delays and flag watching in benches.
//
// PARAMETERS
//   N_FLAGS   2     number of monitored status flags (>=1)
//   CNT_W     16    width of each per-flag edge counter
//   CYC_W     32    width of run-cycle counter
//   RST_HOLD  4     cycles core_reset stays asserted after reset release (>=1)
//   TIMEOUT   0     run-cycle limit; 0 = no limit (must fit in CYC_W)
//
// PORTS
//   clk          in   1              system clock, rising edge
//   reset        in   1              asynchronous, active-low system reset
//   clear        in   1              sync: zero counters/sticky, restart HOLD
//   flags        in   N_FLAGS        CPU status flags, bit0=equal, bit1=zero
//   core_reset   out  1              active-low reset to CPU, registered
//   running      out  1              1 while in RUN
//   timeout      out  1              1 while in STOP
//   cycle_count  out  CYC_W          RUN cycles elapsed, saturating
//   flag_count   out  N_FLAGS*CNT_W  rising-edge count, flag i at [i*CNT_W +: CNT_W]
//   flag_sticky  out  N_FLAGS        bit i set once flag i has had an edge in RUN
//
// BEHAVIOUR
//   Reset (reset=0, asynchronous, immediate):
//   - state=HOLD, hold_cnt=0, core_reset=0, running=0, timeout=0.
//   - cycle_count=0, flag_count=0, flag_sticky=0, flags_q=0.
//   States:
//   - HOLD: core_reset=0. hold_cnt increments each edge. When hold_cnt==RST_HOLD-1,
//     go to RUN. core_reset goes 1 on the RST_HOLD-th rising edge after release.
//   - RUN: core_reset=1, running=1. cycle_count increments each edge, saturates at
//     all-ones. If TIMEOUT!=0 and cycle_count==TIMEOUT-1, go to STOP;
//     cycle_count reads TIMEOUT there.
//   - STOP: core_reset=0, running=0, timeout=1. Counters frozen. Leave only via
//     clear or reset.
//   All outputs are registered; state outputs change on the same edge as the state.
//   Flag edge detection:
//   - flags_q <= flags every cycle in every state; clear does not touch flags_q.
//   - edge[i] = flags[i] & ~flags_q[i]; counted only in RUN.
//   - Counting adds one cycle of latency after the flag rises.
//   - A flag already high on RUN entry is not counted until it falls and rises again.
//   - Level held N cycles = 1 edge. Per-flag counters saturate at 2^CNT_W-1.
//   - Sticky bit is set on the first counted edge.
//   clear, in any state:
//   - Next edge: state=HOLD, hold_cnt=0, core_reset=0, running=0, timeout=0.
//   - cycle_count, flag_count and flag_sticky all return to 0.
//   Precedence: reset > clear > (timeout transition, edge count).
//   - clear in the same cycle as an edge: edge is dropped.
//   - Edge on the cycle RUN->STOP: counted; the transition edge is still a RUN cycle.
//   Reset mid-RUN: core_reset drops asynchronously with reset; no partial counts
//   are retained.
//
// TESTING
//   1 Defaults; reset low 3 cycles then high -> core_reset=0 for 3 edges, =1
//     after 4th edge; running=1; cycle_count=0 then counts 1,2,3...
//   2 RUN: pulse flags[0] 1 cycle, 3 times with gaps; hold flags[1] high 10
//     cycles -> flag_count[0]=3, flag_count[1]=1, flag_sticky=2'b11.
//   3 TIMEOUT=20 -> after 20 RUN edges: timeout=1, running=0, core_reset=0,
//     cycle_count=20. Further flag edges -> counts unchanged.
//   4 CNT_W=4, 20 edges on flags[0] -> flag_count[0]=15 stays 15; no wrap.
//   5 clear in the same cycle as a flags[1] edge in RUN -> next edge: counts
//     all 0, sticky 0, core_reset=0. RUN re-entered after RST_HOLD edges.
//   6 reset asserted mid-RUN between clock edges -> core_reset, running and
//     all counters 0 immediately; release -> normal HOLD sequence repeats.

Source files
------------

// File: rtl/cpu_run_monitor.sv
// Reset sequencer and run monitor for the single-cycle CPU: holds the core in
// reset, counts run cycles and status-flag rising edges, stops at a cycle limit.
module cpu_run_monitor #(
  parameter int unsigned N_FLAGS  = 2,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned CYC_W    = 32,
  parameter int unsigned RST_HOLD = 4,
  parameter int unsigned TIMEOUT  = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic [N_FLAGS-1:0]         flags,
  output logic                       core_reset,
  output logic                       running,
  output logic                       timeout,
  output logic [CYC_W-1:0]           cycle_count,
  output logic [N_FLAGS*CNT_W-1:0]   flag_count,
  output logic [N_FLAGS-1:0]         flag_sticky
);

  localparam int unsigned       HOLD_W    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
  localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_HOLD,
    S_RUN,
    S_STOP
  } state_t;

  state_t                          state_q, state_d;
  logic [HOLD_W-1:0]               hold_q, hold_d;
  logic [CYC_W-1:0]                cyc_q, cyc_d;
  logic [N_FLAGS-1:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_FLAGS-1:0]              sticky_q, sticky_d;
  logic [N_FLAGS-1:0]              flags_q;
  logic                            core_q, run_q, tmo_q;
  logic [N_FLAGS-1:0]              rise;

  assign rise = flags & ~flags_q;

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    cyc_d    = cyc_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    if (clear) begin
      state_d  = S_HOLD;
      hold_d   = '0;
      cyc_d    = '0;
      cnt_d    = '0;
      sticky_d = '0;
    end else begin
      case (state_q)
        S_HOLD: begin
          if (hold_q == HOLD_LAST) begin
            state_d = S_RUN;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
        S_RUN: begin
          if (cyc_q != '1) cyc_d = cyc_q + CYC_W'(1);
          for (int unsigned i = 0; i < N_FLAGS; i++) begin
            if (rise[i]) begin
              if (cnt_q[i] != '1) cnt_d[i] = cnt_q[i] + CNT_W'(1);
              sticky_d[i] = 1'b1;
            end
          end
          // The transition edge itself is still a RUN cycle, so counting above stands.
          if ((TIMEOUT != 0) && (cyc_q == CYC_LAST)) state_d = S_STOP;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_HOLD;
      hold_q   <= '0;
      cyc_q    <= '0;
      cnt_q    <= '0;
      sticky_q <= '0;
      flags_q  <= '0;
      core_q   <= 1'b0;
      run_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      cyc_q    <= cyc_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      flags_q  <= flags;
      core_q   <= (state_d == S_RUN);
      run_q    <= (state_d == S_RUN);
      tmo_q    <= (state_d == S_STOP);
    end
  end

  assign core_reset  = core_q;
  assign running     = run_q;
  assign timeout     = tmo_q;
  assign cycle_count = cyc_q;
  assign flag_count  = cnt_q;
  assign flag_sticky = sticky_q;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Scoreboard bench: three parameterisations share one stimulus stream; a model
// based on "edges since release" predicts every output after each event.
module tb_cpu_run_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear;
  logic [1:0] flags;

  always #5 clk = ~clk;

  logic        core_a, run_a, tmo_a, core_b, run_b, tmo_b, core_c, run_c, tmo_c;
  logic [31:0] cyc_a, cyc_b, cyc_c;
  logic [31:0] fc_a, fc_b;
  logic [7:0]  fc_c;
  logic [1:0]  st_a, st_b, st_c;

  cpu_run_monitor dut_a (
    .clk(clk), .reset(reset), .clear(clear), .flags(flags),
    .core_reset(core_a), .running(run_a), .timeout(tmo_a),
    .cycle_count(cyc_a), .flag_count(fc_a), .flag_sticky(st_a)
  );

  cpu_run_monitor #(.TIMEOUT(20), .RST_HOLD(2)) dut_b (
    .clk(clk), .reset(reset), .clear(clear), .flags(flags),
    .core_reset(core_b), .running(run_b), .timeout(tmo_b),
    .cycle_count(cyc_b), .flag_count(fc_b), .flag_sticky(st_b)
  );

  cpu_run_monitor #(.CNT_W(4), .RST_HOLD(1)) dut_c (
    .clk(clk), .reset(reset), .clear(clear), .flags(flags),
    .core_reset(core_c), .running(run_c), .timeout(tmo_c),
    .cycle_count(cyc_c), .flag_count(fc_c), .flag_sticky(st_c)
  );

  logic        act_core [3];
  logic        act_run  [3];
  logic        act_tmo  [3];
  logic [31:0] act_cyc  [3];
  logic [15:0] act_fc0  [3];
  logic [15:0] act_fc1  [3];
  logic [1:0]  act_st   [3];

  assign act_core[0] = core_a; assign act_core[1] = core_b; assign act_core[2] = core_c;
  assign act_run[0]  = run_a;  assign act_run[1]  = run_b;  assign act_run[2]  = run_c;
  assign act_tmo[0]  = tmo_a;  assign act_tmo[1]  = tmo_b;  assign act_tmo[2]  = tmo_c;
  assign act_cyc[0]  = cyc_a;  assign act_cyc[1]  = cyc_b;  assign act_cyc[2]  = cyc_c;
  assign act_fc0[0]  = fc_a[15:0];  assign act_fc1[0] = fc_a[31:16];
  assign act_fc0[1]  = fc_b[15:0];  assign act_fc1[1] = fc_b[31:16];
  assign act_fc0[2]  = {12'b0, fc_c[3:0]}; assign act_fc1[2] = {12'b0, fc_c[7:4]};
  assign act_st[0]   = st_a;   assign act_st[1]   = st_b;   assign act_st[2]   = st_c;

  typedef struct packed {
    logic        core;
    logic        run;
    logic        tmo;
    logic [31:0] cyc;
    logic [15:0] fc1;
    logic [15:0] fc0;
    logic [1:0]  st;
  } exp_t;
  typedef exp_t [2:0] ent_t;

  ent_t q[$];
  event chk_now;
  bit   started = 1'b0;
  bit   done    = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  // Model: hold length, timeout and counter ceiling per instance.
  longint HOLD [3] = '{4, 2, 1};
  longint TMO  [3] = '{0, 20, 0};
  int     CMAX [3] = '{65535, 65535, 15};
  longint since [3];
  int     cnt0 [3];
  int     cnt1 [3];
  logic [1:0] stk [3];
  logic [1:0] prev;

  function automatic bit in_run(longint s, int d);
    return (s >= HOLD[d]) && ((TMO[d] == 0) || (s - HOLD[d] < TMO[d]));
  endfunction

  function automatic exp_t predict(int d);
    exp_t   e;
    longint s  = since[d];
    longint rn = s - HOLD[d];
    e.run  = in_run(s, d);
    e.core = e.run;
    e.tmo  = (TMO[d] != 0) && (s >= HOLD[d]) && (rn >= TMO[d]);
    if (s < HOLD[d])                    e.cyc = '0;
    else if (TMO[d] != 0 && rn > TMO[d]) e.cyc = 32'(TMO[d]);
    else                                 e.cyc = 32'(rn);
    e.fc0 = 16'(cnt0[d]);
    e.fc1 = 16'(cnt1[d]);
    e.st  = stk[d];
    return e;
  endfunction

  task automatic model_step(input logic r, input logic c, input logic [1:0] f);
    for (int d = 0; d < 3; d++) begin
      if (!r || c) begin
        since[d] = 0; cnt0[d] = 0; cnt1[d] = 0; stk[d] = 2'b00;
      end else begin
        if (in_run(since[d], d)) begin
          if (f[0] && !prev[0]) begin
            if (cnt0[d] < CMAX[d]) cnt0[d]++;
            stk[d][0] = 1'b1;
          end
          if (f[1] && !prev[1]) begin
            if (cnt1[d] < CMAX[d]) cnt1[d]++;
            stk[d][1] = 1'b1;
          end
        end
        since[d]++;
      end
    end
    prev = r ? f : 2'b00;
  endtask

  task automatic tick(input logic r, input logic c, input logic [1:0] f);
    ent_t e;
    bit   fell;
    @(negedge clk);
    fell  = reset && !r;
    reset = r;
    clear = c;
    flags = f;
    model_step(r, c, f);
    for (int d = 0; d < 3; d++) e[d] = predict(d);
    if (fell) begin
      q.push_back(e);
      ->chk_now;
    end
    q.push_back(e);
    started = 1'b1;
  endtask

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d @%0t: got %0d expected %0d", nm, d, $time, act, exp);
    end
  endtask

  initial begin
    ent_t e;
    forever begin
      @(posedge clk or chk_now);
      #1;
      if (started && !done) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL scoreboard_underflow @%0t: got 0 entries expected 1", $time);
        end else begin
          e = q.pop_front();
          for (int d = 0; d < 3; d++) begin
            chk("core_reset",  d, 32'(act_core[d]), 32'(e[d].core));
            chk("running",     d, 32'(act_run[d]),  32'(e[d].run));
            chk("timeout",     d, 32'(act_tmo[d]),  32'(e[d].tmo));
            chk("cycle_count", d, act_cyc[d],       e[d].cyc);
            chk("flag_count0", d, 32'(act_fc0[d]),  32'(e[d].fc0));
            chk("flag_count1", d, 32'(act_fc1[d]),  32'(e[d].fc1));
            chk("flag_sticky", d, 32'(act_st[d]),   32'(e[d].st));
          end
        end
      end
    end
  end

  initial begin
    logic r, c;
    reset = 1'b0; clear = 1'b0; flags = 2'b00; prev = 2'b00;
    for (int d = 0; d < 3; d++) begin
      since[d] = 0; cnt0[d] = 0; cnt1[d] = 0; stk[d] = 2'b00;
    end
    repeat (3) tick(1'b0, 1'b0, 2'b00);
    repeat (10) tick(1'b1, 1'b0, 2'b00);
    repeat (3) begin
      tick(1'b1, 1'b0, 2'b01);
      tick(1'b1, 1'b0, 2'b00);
      tick(1'b1, 1'b0, 2'b00);
    end
    repeat (10) tick(1'b1, 1'b0, 2'b10);
    tick(1'b1, 1'b0, 2'b00);
    repeat (20) tick(1'b1, 1'b0, 2'($urandom_range(0, 3)));
    tick(1'b1, 1'b0, 2'b00);
    tick(1'b1, 1'b1, 2'b10);
    tick(1'b1, 1'b0, 2'b10);
    repeat (20) begin
      tick(1'b1, 1'b0, 2'b01);
      tick(1'b1, 1'b0, 2'b00);
    end
    tick(1'b1, 1'b0, 2'b00);
    tick(1'b0, 1'b0, 2'b00);
    tick(1'b0, 1'b0, 2'b00);
    repeat (8) tick(1'b1, 1'b0, 2'b00);
    repeat (300) begin
      r = ($urandom_range(0, 79) != 0);
      c = ($urandom_range(0, 39) == 0);
      tick(r, c, 2'($urandom_range(0, 3)));
    end
    repeat (3) tick(1'b1, 1'b0, 2'b00);
    @(negedge clk);
    done = 1'b1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
